bip_sequencer: RTL and testbench

BIP_SEQUENCER -- requirements
Module: bip_sequencer

---
 rtl/bip_pkg.sv | 57 +++++
 rtl/bip_branch_eval.sv | 26 ++
 rtl/bip_sequencer.sv | 169 ++++++++++++++++
 tb/tb_bip_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control sequencer: state codes, opcode map,
// accumulator source encodings and memory-operation decode helpers.
package bip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_MEM   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    SELA_MEM = 2'b00,
    SELA_IMM = 2'b01,
    SELA_ALU = 2'b10
  } sela_t;

  // Memory-phase operation, latched in EXEC so MEM no longer depends on Opcode_i
  typedef enum logic [1:0] {
    MOP_LD  = 2'b00,
    MOP_ADD = 2'b01,
    MOP_SUB = 2'b10,
    MOP_STO = 2'b11
  } mem_op_t;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_BGT  = 5'b01010;
  localparam logic [4:0] OP_BGE  = 5'b01011;
  localparam logic [4:0] OP_BLT  = 5'b01100;
  localparam logic [4:0] OP_BLE  = 5'b01101;
  localparam logic [4:0] OP_JMP  = 5'b01110;

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STO);
  endfunction

  function automatic mem_op_t mem_op_decode(input logic [4:0] op);
    mem_op_t m;
    case (op)
      OP_ADD:  m = MOP_ADD;
      OP_SUB:  m = MOP_SUB;
      OP_STO:  m = MOP_STO;
      default: m = MOP_LD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bip_branch_eval.sv
// Branch condition evaluation: decides whether a branch opcode is taken
// from the accumulator negative/zero flags. Non-branch opcodes are never taken.
module bip_branch_eval
  import bip_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic       n,
  input  logic       z,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = z;
      OP_BNE:  taken = ~z;
      OP_BGT:  taken = ~n & ~z;
      OP_BGE:  taken = ~n;
      OP_BLT:  taken = n;
      OP_BLE:  taken = n | z;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/bip_sequencer.sv
// BIP control sequencer: IDLE/FETCH/EXEC/MEM FSM with halt flag.
// Define BIP_STEP_EN to add step_i and single-instruction stepping.
module bip_sequencer
  import bip_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       run_i,
`ifdef BIP_STEP_EN
  input  logic       step_i,
`endif
  input  logic [4:0] Opcode_i,
  input  logic       n_i,
  input  logic       z_i,
  input  logic       ack_i,
  output logic       Wrir_o,
  output logic       Branch_o,
  output logic       Wrpc_o,
  output logic [1:0] SelA_o,
  output logic       SelB_o,
  output logic       Op_o,
  output logic       Wracc_o,
  output logic       Wrram_o,
  output logic       Rdram_o,
  output logic       Halted_o,
  output logic [1:0] State_o
);

  state_t  state_q;
  logic    halted_q;
  mem_op_t mem_op_q;
  logic    taken;

`ifdef BIP_STEP_EN
  localparam state_t RETIRE_ST = ST_IDLE;
  logic started_q;
`else
  localparam state_t RETIRE_ST = ST_FETCH;
`endif

  bip_branch_eval u_branch_eval (
    .opcode (Opcode_i),
    .n      (n_i),
    .z      (z_i),
    .taken  (taken)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      halted_q <= 1'b0;
      mem_op_q <= MOP_LD;
`ifdef BIP_STEP_EN
      started_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
`ifdef BIP_STEP_EN
          // run_i only launches the first instruction; step_i launches the rest
          if ((!started_q && run_i) || (started_q && step_i)) begin
            state_q   <= ST_FETCH;
            started_q <= 1'b1;
          end
`else
          if (run_i) state_q <= ST_FETCH;
`endif
        end
        ST_FETCH: state_q <= ST_EXEC;
        ST_EXEC: begin
          // A halted sequencer stays parked in EXEC until reset
          if (!halted_q) begin
            if (Opcode_i == OP_HLT) begin
              halted_q <= 1'b1;
            end else if (is_mem_op(Opcode_i)) begin
              mem_op_q <= mem_op_decode(Opcode_i);
              state_q  <= ST_MEM;
            end else begin
              state_q <= RETIRE_ST;
            end
          end
        end
        ST_MEM: begin
          if (ack_i) state_q <= RETIRE_ST;
        end
      endcase
    end
  end

  // Strobes are Mealy outputs: EXEC decodes the live opcode and MEM completes
  // in the same cycle ack_i arrives.
  sela_t sel_a;
  logic  wrir, branch, wrpc, sel_b, alu_op, wracc, wrram, rdram;

  always_comb begin
    sel_a  = SELA_MEM;
    wrir   = 1'b0;
    branch = 1'b0;
    wrpc   = 1'b0;
    sel_b  = 1'b0;
    alu_op = 1'b0;
    wracc  = 1'b0;
    wrram  = 1'b0;
    rdram  = 1'b0;
    unique case (state_q)
      ST_IDLE:  ;
      ST_FETCH: wrir = 1'b1;
      ST_EXEC: begin
        if (!halted_q) begin
          case (Opcode_i)
            OP_HLT: ;
            OP_LDI: begin
              wracc = 1'b1;
              wrpc  = 1'b1;
              sel_a = SELA_IMM;
            end
            OP_ADDI, OP_SUBI: begin
              wracc  = 1'b1;
              wrpc   = 1'b1;
              sel_a  = SELA_ALU;
              sel_b  = 1'b1;
              alu_op = (Opcode_i == OP_SUBI);
            end
            OP_LD, OP_ADD, OP_SUB: rdram = 1'b1;
            OP_STO:                wrram = 1'b1;
            OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP: begin
              wrpc   = 1'b1;
              branch = taken;
            end
            default: wrpc = 1'b1;
          endcase
        end
      end
      ST_MEM: begin
        if (mem_op_q == MOP_STO) wrram = 1'b1;
        else                     rdram = 1'b1;
        if (ack_i) begin
          wrpc = 1'b1;
          case (mem_op_q)
            MOP_LD: begin
              wracc = 1'b1;
              sel_a = SELA_MEM;
            end
            MOP_ADD, MOP_SUB: begin
              wracc  = 1'b1;
              sel_a  = SELA_ALU;
              sel_b  = 1'b0;
              alu_op = (mem_op_q == MOP_SUB);
            end
            MOP_STO: ;
          endcase
        end
      end
    endcase
  end

  assign Wrir_o   = wrir;
  assign Branch_o = branch;
  assign Wrpc_o   = wrpc;
  assign SelA_o   = sel_a;
  assign SelB_o   = sel_b;
  assign Op_o     = alu_op;
  assign Wracc_o  = wracc;
  assign Wrram_o  = wrram;
  assign Rdram_o  = rdram;
  assign Halted_o = halted_q || ((state_q == ST_EXEC) && (Opcode_i == OP_HLT));
  assign State_o  = state_q;

endmodule

// File: tb/tb_bip_sequencer.sv
// Directed self-checking bench for bip_sequencer; all outputs are compared
// as one packed vector per cycle against hand-derived expectations.
module tb_bip_sequencer;
  import bip_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [4:0] opc = 5'b00000;
  logic       n = 1'b0;
  logic       z = 1'b0;
  logic       ack = 1'b0;
`ifdef BIP_STEP_EN
  logic       step = 1'b0;
`endif
  logic       Wrir_o, Branch_o, Wrpc_o, SelB_o, Op_o, Wracc_o, Wrram_o, Rdram_o, Halted_o;
  logic [1:0] SelA_o, State_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bip_sequencer dut (
    .clock_i  (clk),
    .reset_i  (rst),
    .run_i    (run),
`ifdef BIP_STEP_EN
    .step_i   (step),
`endif
    .Opcode_i (opc),
    .n_i      (n),
    .z_i      (z),
    .ack_i    (ack),
    .Wrir_o   (Wrir_o),
    .Branch_o (Branch_o),
    .Wrpc_o   (Wrpc_o),
    .SelA_o   (SelA_o),
    .SelB_o   (SelB_o),
    .Op_o     (Op_o),
    .Wracc_o  (Wracc_o),
    .Wrram_o  (Wrram_o),
    .Rdram_o  (Rdram_o),
    .Halted_o (Halted_o),
    .State_o  (State_o)
  );

  // {Wrir, Branch, Wrpc, SelA[1:0], SelB, Op, Wracc, Wrram, Rdram, Halted, State[1:0]}
  logic [12:0] outs;
  assign outs = {Wrir_o, Branch_o, Wrpc_o, SelA_o, SelB_o, Op_o,
                 Wracc_o, Wrram_o, Rdram_o, Halted_o, State_o};

  function automatic logic [12:0] ev(input int wrir, input int br, input int wrpc,
                                     input int sela, input int selb, input int op,
                                     input int wracc, input int wrram, input int rdram,
                                     input int halt, input int st);
    return {wrir[0], br[0], wrpc[0], sela[1:0], selb[0], op[0],
            wracc[0], wrram[0], rdram[0], halt[0], st[1:0]};
  endfunction

  logic [12:0] exp_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    run = 1'b1;
    tick();
    #1;
    exp_v = '0;
    tests++;
    if (outs !== exp_v) begin
      fails++;
      $display("FAIL reset_hold: got %b expected %b", outs, exp_v);
    end
    rst = 1'b0;
    run = 1'b0;
    #1;
    tests++;
    if (outs !== exp_v) begin
      fails++;
      $display("FAIL reset_release_idle: got %b expected %b", outs, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      tests++;
      if (outs !== exp_v) begin
        fails++;
        $display("FAIL idle_no_run[%0d]: got %b expected %b", i, outs, exp_v);
      end
    end
  endtask

  task automatic test_ldi_alu();
    run = 1'b1;
    #1;
    exp_v = '0;
    tests++;
    if (outs !== exp_v) begin
      fails++;
      $display("FAIL idle_with_run: got %b expected %b", outs, exp_v);
    end
    tick();
    run = 1'b0;
    #1;
    exp_v = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tests++;
    if (outs !== exp_v) begin
      fails++;
      $display("FAIL ldi_fetch_cycle1: got %b expected %b", outs, exp_v);
    end
    tick();
    opc = OP_LDI;
    #1;
    exp_v = ev(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 2);
    tests++;
    if (outs !== exp_v) begin
      fails++;
      $display("FAIL ldi_exec_cycle2: got %b expected %b", outs, exp_v);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      exp_v = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tests++;
      if (outs !== exp_v) begin
        fails++;
        $display("FAIL alu_imm_fetch[%0d]: got %b expected %b", k, outs, exp_v);
      end
      tick();
      opc = (k == 0) ? OP_ADDI : OP_SUBI;
      #1;
      exp_v = ev(0, 0, 1, 2, 1, k, 1, 0, 0, 0, 2);
      tests++;
      if (outs !== exp_v) begin
        fails++;
        $display("FAIL alu_imm_exec[%0d]: got %b expected %b", k, outs, exp_v);
      end
    end
  endtask

  task automatic test_branches();
    logic [7:0] br_tab [14];
    logic [7:0] v;
    // {opcode, n, z, taken}
    br_tab = '{
      {OP_BLE, 1'b0, 1'b1, 1'b1}, {OP_BGT, 1'b0, 1'b1, 1'b0},
      {OP_JMP, 1'b1, 1'b0, 1'b1}, {OP_BEQ, 1'b0, 1'b1, 1'b1},
      {OP_BEQ, 1'b1, 1'b0, 1'b0}, {OP_BNE, 1'b0, 1'b0, 1'b1},
      {OP_BNE, 1'b0, 1'b1, 1'b0}, {OP_BGE, 1'b1, 1'b0, 1'b0},
      {OP_BGE, 1'b0, 1'b1, 1'b1}, {OP_BLT, 1'b1, 1'b0, 1'b1},
      {OP_BLT, 1'b0, 1'b0, 1'b0}, {OP_BGT, 1'b0, 1'b0, 1'b1},
      {5'b01111, 1'b1, 1'b1, 1'b0}, {5'b11111, 1'b0, 1'b1, 1'b0}
    };
    for (int i = 0; i < 14; i++) begin
      v = br_tab[i];
      tick();
      #1;
      exp_v = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tests++;
      if (outs !== exp_v) begin
        fails++;
        $display("FAIL branch_fetch[%0d]: got %b expected %b", i, outs, exp_v);
      end
      tick();
      opc = v[7:3];
      n   = v[2];
      z   = v[1];
      #1;
      exp_v = ev(0, int'(v[0]), 1, 0, 0, 0, 0, 0, 0, 0, 2);
      tests++;
      if (outs !== exp_v) begin
        fails++;
        $display("FAIL branch_exec[%0d] op=%b n=%b z=%b: got %b expected %b",
                 i, v[7:3], v[2], v[1], outs, exp_v);
      end
    end
    n = 1'b0;
    z = 1'b0;
  endtask

  task automatic test_mem_read();
    logic [4:0] ops [3];
    int waits [3];
    ops   = '{OP_LD, OP_ADD, OP_SUB};
    waits = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      tick();
      ack = 1'b0;
      #1;
      exp_v = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tests++;
      if (outs !== exp_v) begin
        fails++;
        $display("FAIL rd_fetch[%0d]: got %b expected %b", i, outs, exp_v);
      end
      tick();
      opc = ops[i];
      #1;
      exp_v = ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
      tests++;
      if (outs !== exp_v) begin
        fails++;
        $display("FAIL rd_exec[%0d]: got %b expected %b", i, outs, exp_v);
      end
      for (int w = 0; w < waits[i]; w++) begin
        tick();
        #1;
        exp_v = ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
        tests++;
        if (outs !== exp_v) begin
          fails++;
          $display("FAIL rd_wait[%0d]: got %b expected %b", i, outs, exp_v);
        end
      end
      tick();
      ack = 1'b1;
      #1;
      exp_v = ev(0, 0, 1, (i == 0) ? 0 : 2, 0, (i == 2) ? 1 : 0, 1, 0, 1, 0, 3);
      tests++;
      if (outs !== exp_v) begin
        fails++;
        $display("FAIL rd_ack[%0d]: got %b expected %b", i, outs, exp_v);
      end
    end
  endtask

  task automatic test_sto();
    tick();
    ack = 1'b0;
    #1;
    exp_v = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tests++;
    if (outs !== exp_v) begin
      fails++;
      $display("FAIL sto_fetch: got %b expected %b", outs, exp_v);
    end
    tick();
    opc = OP_STO;
    #1;
    exp_v = ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
    tests++;
    if (outs !== exp_v) begin
      fails++;
      $display("FAIL sto_exec: got %b expected %b", outs, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      ack = (i == 2);
      #1;
      exp_v = ev(0, 0, (i == 2) ? 1 : 0, 0, 0, 0, 0, 1, 0, 0, 3);
      tests++;
      if (outs !== exp_v) begin
        fails++;
        $display("FAIL sto_mem[%0d]: got %b expected %b", i, outs, exp_v);
      end
    end
    tick();
    ack = 1'b0;
    #1;
    exp_v = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tests++;
    if (outs !== exp_v) begin
      fails++;
      $display("FAIL sto_next_fetch: got %b expected %b", outs, exp_v);
    end
  endtask

  task automatic test_reset_mid_mem();
    tick();
    opc = OP_LD;
    #1;
    tick();
    #1;
    exp_v = ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
    tests++;
    if (outs !== exp_v) begin
      fails++;
      $display("FAIL mid_mem_before_reset: got %b expected %b", outs, exp_v);
    end
    rst = 1'b1;
    #1;
    exp_v = '0;
    tests++;
    if (outs !== exp_v) begin
      fails++;
      $display("FAIL mid_mem_reset_same_cycle: got %b expected %b", outs, exp_v);
    end
    tick();
    rst = 1'b0;
    run = 1'b0;
    #1;
    tick();
    #1;
    tests++;
    if (outs !== exp_v) begin
      fails++;
      $display("FAIL post_reset_idle: got %b expected %b", outs, exp_v);
    end
  endtask

  task automatic test_halt();
    run = 1'b1;
    tick();
    run = 1'b0;
    #1;
    exp_v = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tests++;
    if (outs !== exp_v) begin
      fails++;
      $display("FAIL halt_fetch: got %b expected %b", outs, exp_v);
    end
    tick();
    opc = OP_HLT;
    #1;
    exp_v = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    tests++;
    if (outs !== exp_v) begin
      fails++;
      $display("FAIL halt_exec: got %b expected %b", outs, exp_v);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      run = i[0];
      ack = i[1];
      opc = i[0] ? OP_LDI : OP_JMP;
      #1;
      tests++;
      if (outs !== exp_v) begin
        fails++;
        $display("FAIL halt_frozen[%0d]: got %b expected %b", i, outs, exp_v);
      end
    end
    rst = 1'b1;
    run = 1'b0;
    ack = 1'b0;
    #1;
    exp_v = '0;
    tests++;
    if (outs !== exp_v) begin
      fails++;
      $display("FAIL halt_reset_exit: got %b expected %b", outs, exp_v);
    end
    tick();
    rst = 1'b0;
  endtask

`ifdef BIP_STEP_EN
  task automatic test_step();
    int pulses;
    run = 1'b1;
    tick();
    #1;
    tick();
    opc = OP_ADDI;
    #1;
    exp_v = ev(0, 0, 1, 2, 1, 0, 1, 0, 0, 0, 2);
    tests++;
    if (outs !== exp_v) begin
      fails++;
      $display("FAIL step_first_exec: got %b expected %b", outs, exp_v);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      exp_v = '0;
      tests++;
      if (outs !== exp_v) begin
        fails++;
        $display("FAIL step_idle_run_ignored[%0d]: got %b expected %b", i, outs, exp_v);
      end
    end
    run = 1'b0;
    step = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      step = 1'b0;
      #1;
      if (Wracc_o === 1'b1) pulses++;
    end
    tests++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL step_single_wracc: got %0d expected %0d", pulses, 1);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef BIP_STEP_EN
    test_step();
`else
    test_ldi_alu();
    test_branches();
    test_mem_read();
    test_sto();
    test_reset_mid_mem();
    test_halt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
